// File: rtl/ahb_uvc_pkg.sv
// Shared AHB-Lite definitions for the AHB_UVC bench: HTRANS/HBURST encodings,
// arbiter state encoding and the beat count implied by each HBURST code.
package ahb_uvc_pkg;

  localparam int HTRANS_WIDTH = 2;
  localparam int HBURST_WIDTH = 3;
  localparam int BEATS_WIDTH  = 5;  // holds 0..16

  typedef enum logic [HTRANS_WIDTH-1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [HBURST_WIDTH-1:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_OWN    = 2'd1,
    ST_BURST  = 2'd2,
    ST_LOCKED = 2'd3
  } arb_state_e;

  // Total beats of a burst; undefined-length INCR returns 0 (never holds the bus).
  function automatic logic [BEATS_WIDTH-1:0] burst_beats(input hburst_e burst);
    case (burst)
      HBURST_SINGLE:                burst_beats = 5'd1;
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
      default:                      burst_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Round-robin picker: returns the first requester strictly after the pointer,
// wrapping N-1 -> 0; the pointer position itself is considered last.
// Ports:
//   i_req   N  request vector
//   i_ptr   W  index of the most recent winner
//   o_gnt   N  one-hot winner (all-zero when no request)
//   o_valid 1  at least one request present
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic         o_valid
);

  int w_idx;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop can leave a value unassigned and infer a latch.
  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!o_valid && i_req[W'(w_idx)]) begin
        o_gnt[W'(w_idx)] = 1'b1;
        o_valid          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite bus arbiter. Keeps fixed-length bursts and locked
// sequences on one master, parks the bus on DEFAULT_MASTER when idle.
// Ports:
//   hclk, hresetn  clock, asynchronous active-low reset
//   hbusreq/hlock  per-master request and locked-transfer request
//   htrans/hburst  current transfer type / burst type on the bus
//   hready         transfer complete; when low every register holds
//   hgrant         registered one-hot grant
//   hmaster        owner of the current address phase
//   hmastlock      current address phase is locked
module ahb_bus_arbiter
  import ahb_uvc_pkg::*;
#(
  parameter  int NUM_MASTERS    = 4,
  parameter  int DEFAULT_MASTER = 0,
  localparam int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic [NUM_MASTERS-1:0]  hbusreq,
  input  logic [NUM_MASTERS-1:0]  hlock,
  input  logic [HTRANS_WIDTH-1:0] htrans,
  input  logic [HBURST_WIDTH-1:0] hburst,
  input  logic                    hready,
  output logic [NUM_MASTERS-1:0]  hgrant,
  output logic [MW-1:0]           hmaster,
  output logic                    hmastlock
);

  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEFAULT_IDX   = MW'(DEFAULT_MASTER);

  function automatic logic [MW-1:0] onehot_idx(input logic [NUM_MASTERS-1:0] vec);
    logic [MW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (vec[i]) idx = idx | MW'(i);
    end
    return idx;
  endfunction

  arb_state_e                r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0]    r_grant, w_grant_nxt;
  logic [MW-1:0]             r_rr_ptr, w_rr_ptr_nxt;
  logic [MW-1:0]             r_hmaster;
  logic                      r_hmastlock;
  logic [BEATS_WIDTH-1:0]    r_beats_left, w_beats_nxt;

  htrans_e                   w_htrans;
  hburst_e                   w_hburst;
  logic [MW-1:0]             w_owner;
  logic                      w_keep;
  logic [NUM_MASTERS-1:0]    w_pick_gnt;
  logic                      w_pick_valid;
  logic [MW-1:0]             w_pick_idx;

  assign w_htrans   = htrans_e'(htrans);
  assign w_hburst   = hburst_e'(hburst);
  assign w_owner    = onehot_idx(r_grant);
  assign w_pick_idx = onehot_idx(w_pick_gnt);

  rr_pick #(.N(NUM_MASTERS)) u_rr_pick (
    .i_req   (hbusreq),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_pick_gnt),
    .o_valid (w_pick_valid)
  );

  // Counter value after the current transfer completes. NONSEQ reloads from
  // HBURST, SEQ counts down (saturating), IDLE/BUSY hold.
  always_comb begin
    w_beats_nxt = r_beats_left;
    if (w_htrans == HTRANS_NONSEQ) begin
      w_beats_nxt = burst_beats(w_hburst);
    end else if (w_htrans == HTRANS_SEQ && r_beats_left != '0) begin
      w_beats_nxt = r_beats_left - 5'd1;
    end
  end

  // The owner keeps the bus in OWN while it still requests and either asks
  // for a lock or is continuing an undefined-length INCR.
  assign w_keep = (r_state == ST_OWN) && hbusreq[w_owner] &&
                  (hlock[w_owner] || w_htrans == HTRANS_SEQ);

  // Arbitration looks at the counter value after this beat, so the grant
  // moves during the last beat's address phase and the new owner's first
  // address phase follows the burst without a gap.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    if (r_state == ST_LOCKED) begin
      if (!hlock[w_owner] && w_htrans != HTRANS_SEQ) w_state_nxt = ST_OWN;
    end else if (w_beats_nxt > 5'd1) begin
      w_state_nxt = ST_BURST;
    end else if (w_keep) begin
      w_state_nxt = hlock[w_owner] ? ST_LOCKED : ST_OWN;
    end else if (w_pick_valid) begin
      w_grant_nxt  = w_pick_gnt;
      w_rr_ptr_nxt = w_pick_idx;
      w_state_nxt  = hlock[w_pick_idx] ? ST_LOCKED : ST_OWN;
    end else begin
      w_grant_nxt = DEFAULT_GRANT;
      w_state_nxt = ST_PARK;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational blocks.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state      <= ST_PARK;
      r_grant      <= DEFAULT_GRANT;
      r_rr_ptr     <= DEFAULT_IDX;
      r_beats_left <= '0;
      r_hmaster    <= DEFAULT_IDX;
      r_hmastlock  <= 1'b0;
    end else if (hready) begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_beats_left <= w_beats_nxt;
      r_hmaster    <= w_owner;
      r_hmastlock  <= hlock[w_owner];
    end
  end

  assign hgrant    = r_grant;
  assign hmaster   = r_hmaster;
  assign hmastlock = r_hmastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (4 masters, default master 0).
// Each step drives one bus cycle and queues the outputs expected after the
// next rising edge; the queue is popped and compared 1 ns after that edge.
module tb_ahb_bus_arbiter;
  import ahb_uvc_pkg::*;

  logic       hclk;
  logic       hresetn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic [1:0] master;
    logic       lock;
  } exp_t;

  exp_t sb[$];

  ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant must be one-hot at every sampled point.
  always @(negedge hclk) begin
    n_tests++;
    assert ($onehot(hgrant)) else begin
      n_fail++;
      $error("FAIL onehot: observed %b expected one-hot", hgrant);
    end
  end

  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lck,
                      input htrans_e tr, input hburst_e bu, input logic rdy,
                      input logic [3:0] e_grant, input logic [1:0] e_master,
                      input logic e_lock);
    exp_t e, got;
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    e.tag = tag; e.grant = e_grant; e.master = e_master; e.lock = e_lock;
    sb.push_back(e);
    @(posedge hclk);
    #1;
    got = sb.pop_front();
    check({got.tag, ".hgrant"},    32'(hgrant),    32'(got.grant));
    check({got.tag, ".hmaster"},   32'(hmaster),   32'(got.master));
    check({got.tag, ".hmastlock"}, 32'(hmastlock), 32'(got.lock));
  endtask

  initial begin
    hresetn = 1'b1;
    hbusreq = '0; hlock = '0; hready = 1'b1;
    htrans  = HTRANS_IDLE; hburst = HBURST_SINGLE;
    #2 hresetn = 1'b0;
    #1;
    check("rst0.hgrant",    32'(hgrant),    32'h1);
    check("rst0.hmaster",   32'(hmaster),   32'h0);
    check("rst0.hmastlock", 32'(hmastlock), 32'h0);
    @(posedge hclk); @(posedge hclk); #1;
    hresetn = 1'b1;

    // Round-robin over four single transfers: grant order 1,2,3,0,1.
    step("rr_a", 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
    step("rr_b", 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0);
    step("rr_c", 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b1000, 2'd2, 1'b0);
    step("rr_d", 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0001, 2'd3, 1'b0);
    step("rr_e", 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);

    // M1 INCR4, M2 requests from beat 1; grant moves on the 3rd SEQ.
    step("b4_ns", 4'b0010, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, 4'b0010, 2'd1, 1'b0);
    step("b4_s1", 4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR4, 1'b1, 4'b0010, 2'd1, 1'b0);
    step("b4_s2", 4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR4, 1'b1, 4'b0010, 2'd1, 1'b0);
    step("b4_s3", 4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR4, 1'b1, 4'b0100, 2'd1, 1'b0);
    step("b4_hm", 4'b0100, 4'b0000, HTRANS_IDLE,   HBURST_INCR4, 1'b1, 4'b0100, 2'd2, 1'b0);

    // M2 WRAP8 with three wait states after the first SEQ; others request.
    step("w8_ns", 4'b0100, 4'b0000, HTRANS_NONSEQ, HBURST_WRAP8, 1'b1, 4'b0100, 2'd2, 1'b0);
    step("w8_s1", 4'b1101, 4'b0000, HTRANS_SEQ,    HBURST_WRAP8, 1'b1, 4'b0100, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++)
      step("w8_wait", 4'b1101, 4'b0000, HTRANS_SEQ, HBURST_WRAP8, 1'b0, 4'b0100, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++)
      step("w8_hold", 4'b1101, 4'b0000, HTRANS_SEQ, HBURST_WRAP8, 1'b1, 4'b0100, 2'd2, 1'b0);
    step("w8_last", 4'b1101, 4'b0000, HTRANS_SEQ,  HBURST_WRAP8, 1'b1, 4'b1000, 2'd2, 1'b0);

    // M3 locked INCR with all others requesting; released by IDLE, then M0.
    step("lk_ns",  4'b1111, 4'b1000, HTRANS_NONSEQ, HBURST_INCR, 1'b1, 4'b1000, 2'd3, 1'b1);
    step("lk_s1",  4'b1111, 4'b1000, HTRANS_SEQ,    HBURST_INCR, 1'b1, 4'b1000, 2'd3, 1'b1);
    step("lk_s2",  4'b1111, 4'b1000, HTRANS_SEQ,    HBURST_INCR, 1'b1, 4'b1000, 2'd3, 1'b1);
    step("lk_drop",4'b1111, 4'b0000, HTRANS_SEQ,    HBURST_INCR, 1'b1, 4'b1000, 2'd3, 1'b0);
    step("lk_idle",4'b0111, 4'b0000, HTRANS_IDLE,   HBURST_INCR, 1'b1, 4'b1000, 2'd3, 1'b0);
    step("lk_m0",  4'b0111, 4'b0000, HTRANS_IDLE,   HBURST_INCR, 1'b1, 4'b0001, 2'd3, 1'b0);

    // Park: no request (M1 hlock alone is ignored) -> default master.
    step("pk_a", 4'b0000, 4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
    step("pk_b", 4'b0000, 4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);

    // Winner with hlock enters LOCKED at grant; locked INCR8 then reset.
    step("lg_gnt", 4'b0100, 4'b0100, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0100, 2'd0, 1'b0);
    step("lg_ns",  4'b0101, 4'b0100, HTRANS_NONSEQ, HBURST_INCR,   1'b1, 4'b0100, 2'd2, 1'b1);
    step("i8_ns",  4'b0101, 4'b0100, HTRANS_NONSEQ, HBURST_INCR8,  1'b1, 4'b0100, 2'd2, 1'b1);
    step("i8_s1",  4'b0101, 4'b0100, HTRANS_SEQ,    HBURST_INCR8,  1'b1, 4'b0100, 2'd2, 1'b1);
    #2 hresetn = 1'b0;
    #1;
    check("rst1.hgrant",    32'(hgrant),    32'h1);
    check("rst1.hmaster",   32'(hmaster),   32'h0);
    check("rst1.hmastlock", 32'(hmastlock), 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1;

    // After reset the aborted burst leaves no residual count: a stray SEQ
    // does not hold the bus and M1 wins immediately.
    step("ar_park", 4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
    step("ar_seq",  4'b0010, 4'b0000, HTRANS_SEQ,  HBURST_INCR8,  1'b1, 4'b0010, 2'd0, 1'b0);
    step("ar_own",  4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: observed %0d leftover entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
